// File: rtl/descriptor_input_queue_pkg.sv
// Shared descriptor-stage definitions: default geometry, descriptor field layout and read FSM encodings.
package tsn_desc_pkg;

    localparam int DESC_W_DEF     = 40;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int DROP_CNT_W_DEF = 16;

    // bufid occupies the top of the descriptor, tsntag the remainder
    localparam int DESC_BUFID_MSB  = 39;
    localparam int DESC_BUFID_LSB  = 31;
    localparam int DESC_TSNTAG_MSB = 30;
    localparam int DESC_TSNTAG_LSB = 0;

    typedef enum logic {
        RD_IDLE    = 1'b0,
        RD_PRESENT = 1'b1
    } rd_state_t;

    function automatic logic [DESC_BUFID_MSB-DESC_BUFID_LSB:0] desc_bufid(
        input logic [DESC_W_DEF-1:0] desc
    );
        return desc[DESC_BUFID_MSB:DESC_BUFID_LSB];
    endfunction

endpackage

// File: rtl/descriptor_input_queue_if.sv
// Descriptor queue bus: write side from the host-input mux, read side to the input-queue manager, status.
interface descriptor_input_queue_if #(
    parameter int DESC_W     = tsn_desc_pkg::DESC_W_DEF,
    parameter int DEPTH_LOG2 = tsn_desc_pkg::DEPTH_LOG2_DEF,
    parameter int DROP_CNT_W = tsn_desc_pkg::DROP_CNT_W_DEF
) ();
    import tsn_desc_pkg::*;

    // Handshake: a write strobe is accepted only if the queue was not full at that edge, and the
    // acceptance is pulsed on o_descriptor_ack the following cycle; o_descriptor_wr is a level that
    // holds ov_descriptor stable until i_descriptor_ack is seen high at an edge while it is asserted.
    logic [DESC_W-1:0]     iv_descriptor;
    logic                  i_descriptor_wr;
    logic                  o_descriptor_ack;
    logic [DESC_W-1:0]     ov_descriptor;
    logic                  o_descriptor_wr;
    logic                  i_descriptor_ack;
    logic [DEPTH_LOG2:0]   ov_queue_usedw;
    logic                  o_queue_full;
    logic                  o_queue_empty;
    logic [DROP_CNT_W-1:0] ov_drop_cnt;
    rd_state_t             rd_state;

    modport slave (
        input  iv_descriptor, i_descriptor_wr, i_descriptor_ack,
        output o_descriptor_ack, ov_descriptor, o_descriptor_wr,
        output ov_queue_usedw, o_queue_full, o_queue_empty, ov_drop_cnt, rd_state
    );

    modport master (
        output iv_descriptor, i_descriptor_wr, i_descriptor_ack,
        input  o_descriptor_ack, ov_descriptor, o_descriptor_wr,
        input  ov_queue_usedw, o_queue_full, o_queue_empty, ov_drop_cnt, rd_state
    );

endinterface

// File: rtl/descriptor_input_queue_ram.sv
// Descriptor storage: register array with synchronous write and combinational read.
module desc_queue_ram #(
    parameter int DESC_W = 40,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DESC_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DESC_W-1:0] rdata
);

    logic [DESC_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/descriptor_input_queue.sv
// Descriptor FIFO between the host-input descriptor mux and the input-queue manager.
// Optional saturating drop counter enabled by defining DESC_QUEUE_DROP_CNT_EN.
module descriptor_input_queue #(
    parameter int DESC_W     = tsn_desc_pkg::DESC_W_DEF,
    parameter int DEPTH_LOG2 = tsn_desc_pkg::DEPTH_LOG2_DEF,
    parameter int DROP_CNT_W = tsn_desc_pkg::DROP_CNT_W_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    descriptor_input_queue_if.slave   bus
);
    import tsn_desc_pkg::*;

    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  ack_q;
    logic                  push;
    logic                  pop;
    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [DESC_W-1:0]     head_q;
    logic [DESC_W-1:0]     head_nxt;
    logic [DESC_W-1:0]     ram_rdata;
    logic [DESC_W-1:0]     next_head;

    // Full is the registered value, so a pop on the same edge never admits a write.
    assign push       = bus.i_descriptor_wr && !full_q;
    assign pop        = (state == RD_PRESENT) && bus.i_descriptor_ack;
    assign rd_ptr_nxt = pop ? (rd_ptr + PTR_ONE) : rd_ptr;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    desc_queue_ram #(
        .DESC_W (DESC_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (i_clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.iv_descriptor),
        .raddr (rd_ptr_nxt),
        .rdata (ram_rdata)
    );

    // With one entry left and a same-edge push, the new head is the word being written right now.
    assign next_head = (push && (wr_ptr == rd_ptr_nxt)) ? bus.iv_descriptor : ram_rdata;

    always_comb begin
        state_nxt = state;
        head_nxt  = head_q;
        case (state)
            RD_IDLE: begin
                head_nxt = '0;
                if (count != '0) begin
                    head_nxt  = next_head;
                    state_nxt = RD_PRESENT;
                end
            end
            RD_PRESENT: begin
                if (pop) begin
                    if (count_nxt != '0) begin
                        head_nxt = next_head;
                    end else begin
                        head_nxt  = '0;
                        state_nxt = RD_IDLE;
                    end
                end
            end
            default: begin
                head_nxt  = '0;
                state_nxt = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ack_q   <= 1'b0;
            state   <= RD_IDLE;
            head_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr  <= rd_ptr_nxt;
            count   <= count_nxt;
            full_q  <= (count_nxt == DEPTH_CNT);
            empty_q <= (count_nxt == '0);
            ack_q   <= push;
            state   <= state_nxt;
            head_q  <= head_nxt;
        end
    end

`ifdef DESC_QUEUE_DROP_CNT_EN
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = 1;

    logic [DROP_CNT_W-1:0] drop_cnt;
    logic                  drop;

    assign drop = bus.i_descriptor_wr && full_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_ONE;
        end
    end

    assign bus.ov_drop_cnt = drop_cnt;
`else
    assign bus.ov_drop_cnt = '0;
`endif

    assign bus.o_descriptor_ack = ack_q;
    assign bus.ov_descriptor    = head_q;
    assign bus.o_descriptor_wr  = (state == RD_PRESENT);
    assign bus.ov_queue_usedw   = count;
    assign bus.o_queue_full     = full_q;
    assign bus.o_queue_empty    = empty_q;
    assign bus.rd_state         = state;

endmodule
